// File: rtl/stim_player.sv
// Stimulus sequencer: a host loads a small table of drive entries with hold
// counts, then the block replays them cycle-accurately onto registered outputs.
module stim_player #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [7:0]                   ld_in1,
  input  logic                         ld_in2,
  input  logic                         ld_in3,
  input  logic [CNT_W-1:0]             ld_rep,
  input  logic                         clear,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic [7:0]                   drv_in1,
  output logic                         drv_in2,
  output logic                         drv_in3,
  output logic                         drv_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // state | meaning
  // IDLE  | table loadable, waiting for start
  // PLAY  | sequencing entries; drive outputs follow one cycle behind idx
  typedef enum logic {IDLE, PLAY} state_t;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int EW = 10 + CNT_W;

  logic [EW-1:0]    tbl [DEPTH];
  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0] hc, hc_nxt;
  logic             loop_q, loop_nxt;
  logic             fin_q, fin_nxt;
  logic [CW-1:0]    count_nxt;
  logic             load_en;
  logic             last;
  logic             drv_valid_nxt;
  logic [EW-1:0]    cur;
  logic [EW-1:0]    nxt_ent;
  logic [EW-1:0]    first_ent;

  assign busy      = (state == PLAY);
  assign ld_ready  = !busy && (count < CW'(DEPTH)) && !clear && !start;
  assign load_en   = ld_valid && ld_ready;
  assign cur       = tbl[idx];
  assign nxt_ent   = tbl[idx + IW'(1)];
  assign first_ent = tbl[0];
  assign last      = ({1'b0, idx} == (count - CW'(1)));

  // Drive stage is registered from the current entry, so it trails idx by one cycle.
  assign drv_valid_nxt = (state == PLAY) && !stop;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hc_nxt    = hc;
    loop_nxt  = loop_q;
    fin_nxt   = 1'b0;
    count_nxt = count;

    if (!busy && clear)
      count_nxt = '0;
    else if (load_en)
      count_nxt = count + CW'(1);

    case (state)
      IDLE: begin
        if (start && !stop) begin
          // A same-cycle clear empties the table first, so this is an empty start.
          if (count == '0 || clear) begin
            fin_nxt = 1'b1;
          end else begin
            state_nxt = PLAY;
            loop_nxt  = loop;
            idx_nxt   = '0;
            hc_nxt    = first_ent[CNT_W-1:0];
          end
        end
      end
      PLAY: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (hc != '0) begin
          hc_nxt = hc - CNT_W'(1);
        end else if (!last) begin
          idx_nxt = idx + IW'(1);
          hc_nxt  = nxt_ent[CNT_W-1:0];
        end else if (loop_q) begin
          idx_nxt = '0;
          hc_nxt  = first_ent[CNT_W-1:0];
        end else begin
          state_nxt = IDLE;
          fin_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      hc        <= '0;
      loop_q    <= 1'b0;
      fin_q     <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      drv_valid <= 1'b0;
      drv_in1   <= '0;
      drv_in2   <= 1'b0;
      drv_in3   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      hc        <= hc_nxt;
      loop_q    <= loop_nxt;
      fin_q     <= fin_nxt;
      done      <= fin_q;
      count     <= count_nxt;
      drv_valid <= drv_valid_nxt;
      {drv_in1, drv_in2, drv_in3} <= drv_valid_nxt ? cur[EW-1:CNT_W] : 10'd0;
    end
  end

  // Table storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (load_en)
      tbl[count[IW-1:0]] <= {ld_in1, ld_in2, ld_in3, ld_rep};
  end

endmodule

// File: tb/tb_stim_player.sv
// Self-checking bench for stim_player: table-driven basic replay, hand-written
// corner sequences, and randomized tables checked against an expanded-sequence model.
module tb_stim_player;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] ld_in1 = '0;
  logic       ld_in2 = 1'b0;
  logic       ld_in3 = 1'b0;
  logic [7:0] ld_rep = '0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] drv_in1;
  logic       drv_in2;
  logic       drv_in3;
  logic       drv_valid;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int errors = 0;
  int checks = 0;

  stim_player #(.DEPTH(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_in1(ld_in1), .ld_in2(ld_in2), .ld_in3(ld_in3), .ld_rep(ld_rep),
    .clear(clear), .start(start), .stop(stop), .loop(loop),
    .drv_in1(drv_in1), .drv_in2(drv_in2), .drv_in3(drv_in3),
    .drv_valid(drv_valid), .busy(busy), .done(done), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] in1;
    logic       in2;
    logic       in3;
    logic       valid;
    logic       done;
  } vec_t;

  typedef struct {
    logic [7:0] in1;
    logic       in2;
    logic       in3;
    int         rep;
  } ent_t;

  ent_t       mq[$];
  logic [9:0] seq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_drv(input string name, input logic [9:0] val, input logic v);
    chk(name, {21'd0, drv_valid, drv_in1, drv_in2, drv_in3}, {21'd0, v, val});
  endtask

  task automatic load(input logic [7:0] a, input logic b, input logic c, input logic [7:0] r);
    ld_valid = 1'b1;
    ld_in1 = a; ld_in2 = b; ld_in3 = c; ld_rep = r;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic clear_table();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Reference: each entry expands to rep+1 identical drive cycles.
  task automatic build_seq();
    seq.delete();
    foreach (mq[i])
      for (int r = 0; r <= mq[i].rep; r++)
        seq.push_back({mq[i].in1, mq[i].in2, mq[i].in3});
  endtask

  initial begin
    vec_t bv[7];
    int   nv;
    int   n;
    int   len;
    logic lp;

    bv[0] = '{8'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    bv[1] = '{8'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    bv[2] = '{8'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    bv[3] = '{8'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    bv[4] = '{8'd7, 1'b1, 1'b1, 1'b1, 1'b0};
    bv[5] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    bv[6] = '{8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_drv("rst_drv", 10'd0, 1'b0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);

    // Basic replay, table-driven expectations from start edge +1 .. +7
    load(8'd3, 1'b0, 1'b1, 8'd0);
    load(8'd5, 1'b1, 1'b0, 8'd2);
    load(8'd7, 1'b1, 1'b1, 8'd0);
    chk("basic_count", 32'(count), 32'd3);
    start = 1'b1; loop = 1'b0;
    step();
    start = 1'b0;
    chk("basic_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_drv($sformatf("basic_drv%0d", i), {bv[i].in1, bv[i].in2, bv[i].in3}, bv[i].valid);
      chk($sformatf("basic_done%0d", i), 32'(done), 32'(bv[i].done));
    end
    chk("basic_count_kept", 32'(count), 32'd3);

    // Full table, then empty start
    clear_table();
    for (int i = 0; i < 16; i++) load(8'(i + 16), i[0], i[1], 8'd0);
    chk("full_count", 32'(count), 32'd16);
    ld_valid = 1'b1; #1;
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    step();
    ld_valid = 1'b0;
    chk("full_17th", 32'(count), 32'd16);
    clear_table();
    chk("clear_count", 32'(count), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_drv("empty_drv0", 10'd0, 1'b0);
    chk("empty_done0", 32'(done), 32'd0);
    step();
    chk("empty_done1", 32'(done), 32'd1);
    chk_drv("empty_drv1", 10'd0, 1'b0);
    step();
    chk("empty_done2", 32'(done), 32'd0);

    // Loop and stop, plus collisions during PLAY
    load(8'hA1, 1'b1, 1'b0, 8'd0);
    load(8'hB2, 1'b0, 1'b1, 8'd0);
    start = 1'b1; loop = 1'b1;
    step();
    start = 1'b0; loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_drv($sformatf("loop_drv%0d", i), i[0] ? {8'hB2, 1'b0, 1'b1} : {8'hA1, 1'b1, 1'b0}, 1'b1);
    end
    ld_valid = 1'b1; clear = 1'b1; start = 1'b1; #1;
    chk("play_ld_ready", 32'(ld_ready), 32'd0);
    step();
    ld_valid = 1'b0; clear = 1'b0; start = 1'b0;
    chk("play_count", 32'(count), 32'd2);
    chk("play_busy", 32'(busy), 32'd1);
    chk("play_drv", 32'(drv_valid), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_drv("stop_drv", 10'd0, 1'b0);
    chk("stop_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stop_nodone%0d", i), 32'(done), 32'd0);
      step();
    end

    // start+ld_valid in IDLE: load refused, replay proceeds
    ld_valid = 1'b1; ld_in1 = 8'h55; ld_rep = 8'd0; start = 1'b1;
    step();
    ld_valid = 1'b0; start = 1'b0;
    chk("coll_load_count", 32'(count), 32'd2);
    step(); step(); step();
    chk("coll_load_done", 32'(done), 32'd1);
    step();
    // start+stop in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("coll_ss_busy", 32'(busy), 32'd0);
    step();
    chk_drv("coll_ss_drv", 10'd0, 1'b0);
    step();
    chk("coll_ss_done", 32'(done), 32'd0);

    // Max hold: rep=255 held 256 cycles
    clear_table();
    load(8'h9C, 1'b1, 1'b1, 8'd255);
    start = 1'b1;
    step();
    start = 1'b0;
    nv = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (drv_valid) nv++;
      else break;
    end
    chk("maxhold_cycles", 32'(nv), 32'd256);
    chk("maxhold_done", 32'(done), 32'd1);
    step();

    // Reset mid-replay during the 2nd entry
    clear_table();
    load(8'd3, 1'b0, 1'b1, 8'd0);
    load(8'd5, 1'b1, 1'b0, 8'd2);
    load(8'd7, 1'b1, 1'b1, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk_drv("mid_entry2", {8'd5, 1'b1, 1'b0}, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_drv("mid_rst_drv", 10'd0, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_start_busy", 32'(busy), 32'd0);
    step();
    chk("mid_start_done", 32'(done), 32'd1);
    chk_drv("mid_start_drv", 10'd0, 1'b0);
    step();

    // Randomized tables against the expanded-sequence model
    for (int t = 0; t < 8; t++) begin
      clear_table();
      mq.delete();
      n = $urandom_range(1, 6);
      for (int k = 0; k < 60 && mq.size() < n; k++) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_in1 = 8'($urandom);
        ld_in2 = 1'($urandom);
        ld_in3 = 1'($urandom);
        ld_rep = 8'($urandom_range(0, 3));
        #1;
        chk("rnd_ld_ready", 32'(ld_ready), 32'(mq.size() < 16));
        if (ld_valid) mq.push_back('{ld_in1, ld_in2, ld_in3, int'(ld_rep)});
        step();
      end
      ld_valid = 1'b0;
      chk("rnd_count", 32'(count), 32'(mq.size()));
      build_seq();
      lp = t[0];
      start = 1'b1; loop = lp;
      step();
      start = 1'b0; loop = 1'b0;
      if (!lp) begin
        foreach (seq[i]) begin
          step();
          chk_drv("rnd_drv", seq[i], 1'b1);
        end
        step();
        chk("rnd_done", 32'(done), 32'd1);
        chk_drv("rnd_end_drv", 10'd0, 1'b0);
        step();
        chk("rnd_done_drop", 32'(done), 32'd0);
      end else begin
        len = 2 * seq.size() + $urandom_range(0, 5);
        for (int i = 0; i < len; i++) begin
          step();
          chk_drv("rnd_loop_drv", seq[i % seq.size()], 1'b1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_drv("rnd_stop_drv", 10'd0, 1'b0);
        step();
        chk("rnd_stop_nodone", 32'(done), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
